shwr_integral_mc: RTL and testbench

Parametrised multi-channel successor to the single-channel shower integral block.
- Tracks per-channel ADC baselines while idle and freezes them on TRIGGER.
- Integrates pre-delayed, baseline-subtracted samples over a programmable window, tracking peak and saturation.
- Publishes all results together, with a one-cycle DONE strobe, to the readout/register interface of sde_trigger.

---
 rtl/shwr_integral_mc.sv | 226 ++++++++++++++++++++++
 tb/tb_shwr_integral_mc.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/shwr_integral_mc.sv
// shwr_integral_mc
//
// Multi-channel shower integral block. Each channel tracks its ADC baseline
// while idle, freezes it on TRIGGER, then integrates the pre-delayed,
// baseline-subtracted samples over a programmable window. It also tracks the
// peak sample and a saturation flag. All channel results are published
// together with a one-cycle DONE strobe.
//
// Ports:
//   CLK120        in   120 MHz clock
//   RESET         in   synchronous, active-high reset
//   ADC           in   NCH packed samples, channel 0 in the LSBs
//   TRIGGER       in   start request, level-sampled while idle
//   WINDOW_LEN    in   integration bins (0 behaves as 1), sampled at trigger
//   BASELINE_INIT in   integer baseline loaded at reset
//   BUSY          out  high while integrating
//   DONE          out  one-cycle strobe, result outputs valid
//   INTEGRAL      out  clamped integral per channel
//   PEAK          out  peak sample minus rounded baseline, floored at 0
//   BASELINE      out  frozen baseline with BL_EXTRA fraction bits
//   SATURATED     out  a window sample reached SAT_LEVEL
//   OVERFLOW      out  the integral exceeded its output range
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | baselines track ADCD; TRIGGER freezes them and starts a window
// S_INTEG | accumulate one bin per cycle; bin counter counts down to 1
// S_DONE  | DONE strobe with fresh results; TRIGGER ignored

module shwr_integral_mc #(
    parameter int NCH        = 3,
    parameter int ADC_WIDTH  = 12,
    parameter int AREA_WIDTH = 19,
    parameter int FRAC_WIDTH = 6,
    parameter int BL_EXTRA   = 2,
    parameter int PRE_DLY    = 8,
    parameter int SAT_LEVEL  = 4095
) (
    input  logic                                   CLK120,
    input  logic                                   RESET,
    input  logic [NCH*ADC_WIDTH-1:0]               ADC,
    input  logic                                   TRIGGER,
    input  logic [11:0]                            WINDOW_LEN,
    input  logic [ADC_WIDTH-1:0]                   BASELINE_INIT,
    output logic                                   BUSY,
    output logic                                   DONE,
    output logic [NCH*AREA_WIDTH-1:0]              INTEGRAL,
    output logic [NCH*ADC_WIDTH-1:0]               PEAK,
    output logic [NCH*(ADC_WIDTH+BL_EXTRA)-1:0]    BASELINE,
    output logic [NCH-1:0]                         SATURATED,
    output logic [NCH-1:0]                         OVERFLOW
);

    localparam int BL_W  = ADC_WIDTH + FRAC_WIDTH;
    localparam int ACC_W = AREA_WIDTH + FRAC_WIDTH + 2;
    localparam int BLO_W = ADC_WIDTH + BL_EXTRA;

    // Accumulator clamp points; the negative clamp only keeps very long
    // negative windows from wrapping, the reported result is 0 either way.
    localparam logic signed [ACC_W:0] POS_LIM =
        $signed((ACC_W+1)'(1) << (AREA_WIDTH + FRAC_WIDTH));
    localparam logic signed [ACC_W:0] NEG_LIM = -POS_LIM;
    localparam logic [BL_W:0]         BL_HALF = (BL_W+1)'(1) << (FRAC_WIDTH - 1);
    localparam logic [ADC_WIDTH-1:0]  SAT_CODE = ADC_WIDTH'(SAT_LEVEL);

    typedef enum logic [1:0] {S_IDLE, S_INTEG, S_DONE} state_t;

    state_t      state, state_nxt;
    logic [11:0] bin_cnt;
    logic        start, track, last;

    logic [NCH*ADC_WIDTH-1:0] dly [PRE_DLY];
    logic [NCH*ADC_WIDTH-1:0] adcd;

    wire [NCH*AREA_WIDTH-1:0] integral_w;
    wire [NCH*ADC_WIDTH-1:0]  peak_w;
    wire [NCH*BLO_W-1:0]      baseline_w;
    wire [NCH-1:0]            sat_w;
    wire [NCH-1:0]            ovf_w;

    // Pre-trigger look-back delay line, running in every state.
    always_ff @(posedge CLK120) begin
        if (RESET) begin
            for (int i = 0; i < PRE_DLY; i++) dly[i] <= '0;
        end else begin
            dly[0] <= ADC;
            for (int i = 1; i < PRE_DLY; i++) dly[i] <= dly[i-1];
        end
    end

    assign adcd = dly[PRE_DLY-1];

    always_ff @(posedge CLK120) begin
        if (RESET) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (TRIGGER) state_nxt = S_INTEG;
            S_INTEG: if (bin_cnt == 12'd1) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        BUSY  = (state == S_INTEG);
        DONE  = (state == S_DONE);
        start = (state == S_IDLE) && TRIGGER;
        track = (state == S_IDLE) && !TRIGGER;
        last  = (state == S_INTEG) && (bin_cnt == 12'd1);
    end

    always_ff @(posedge CLK120) begin
        if (RESET)      bin_cnt <= '0;
        else if (start) bin_cnt <= (WINDOW_LEN == 12'd0) ? 12'd1 : WINDOW_LEN;
        else if (BUSY)  bin_cnt <= bin_cnt - 12'd1;
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic [ADC_WIDTH-1:0]    sample;
        logic [BL_W-1:0]         level, bl;
        logic signed [ACC_W:0]   sum;
        logic signed [ACC_W-1:0] acc, acc_nxt;
        logic [ADC_WIDTH-1:0]    peak, peak_nxt;
        logic                    sat, sat_nxt, ovf, ovf_nxt;
        logic [BL_W:0]           bl_half;
        logic [ADC_WIDTH:0]      bl_rnd;

        logic [AREA_WIDTH-1:0]   integral_r;
        logic [ADC_WIDTH-1:0]    peak_r;
        logic [BLO_W-1:0]        bl_out_r;
        logic                    sat_r, ovf_r;

        assign sample  = adcd[g*ADC_WIDTH +: ADC_WIDTH];
        assign level   = {sample, {FRAC_WIDTH{1'b0}}};
        assign bl_half = {1'b0, bl} + BL_HALF;
        assign bl_rnd  = bl_half[BL_W:FRAC_WIDTH];

        // Slow tracker: one fractional LSB per cycle, holds on a flat input.
        // Not updated in the trigger cycle, so the frozen value is the one
        // held entering it.
        always_ff @(posedge CLK120) begin
            if (RESET)
                bl <= {BASELINE_INIT, {FRAC_WIDTH{1'b0}}};
            else if (track) begin
                if (level > bl)      bl <= bl + BL_W'(1);
                else if (level < bl) bl <= bl - BL_W'(1);
            end
        end

        always_comb begin
            sum = $signed({acc[ACC_W-1], acc})
                + $signed({{(ACC_W+1-BL_W){1'b0}}, level})
                - $signed({{(ACC_W+1-BL_W){1'b0}}, bl});
            acc_nxt = sum[ACC_W-1:0];
            ovf_nxt = ovf;
            if (ovf || sum >= POS_LIM) begin
                acc_nxt = POS_LIM[ACC_W-1:0];
                ovf_nxt = 1'b1;
            end else if (sum < NEG_LIM) begin
                acc_nxt = NEG_LIM[ACC_W-1:0];
            end
            peak_nxt = (sample > peak) ? sample : peak;
            sat_nxt  = sat | (sample >= SAT_CODE);
        end

        always_ff @(posedge CLK120) begin
            if (RESET || start) begin
                acc  <= '0;
                peak <= '0;
                sat  <= 1'b0;
                ovf  <= 1'b0;
            end else if (BUSY) begin
                acc  <= acc_nxt;
                peak <= peak_nxt;
                sat  <= sat_nxt;
                ovf  <= ovf_nxt;
            end
        end

        // Results are taken from the last bin's update so they are valid
        // in the DONE cycle itself.
        always_ff @(posedge CLK120) begin
            if (RESET) begin
                integral_r <= '0;
                peak_r     <= '0;
                bl_out_r   <= {BASELINE_INIT, {BL_EXTRA{1'b0}}};
                sat_r      <= 1'b0;
                ovf_r      <= 1'b0;
            end else if (last) begin
                if (acc_nxt < 0) begin
                    integral_r <= '0;
                    ovf_r      <= 1'b0;
                end else if (ovf_nxt) begin
                    integral_r <= '1;
                    ovf_r      <= 1'b1;
                end else begin
                    integral_r <= acc_nxt[FRAC_WIDTH +: AREA_WIDTH];
                    ovf_r      <= 1'b0;
                end
                if ({1'b0, peak_nxt} > bl_rnd)
                    peak_r <= peak_nxt - bl_rnd[ADC_WIDTH-1:0];
                else
                    peak_r <= '0;
                bl_out_r <= bl[BL_W-1:FRAC_WIDTH-BL_EXTRA];
                sat_r    <= sat_nxt;
            end
        end

        assign integral_w[g*AREA_WIDTH +: AREA_WIDTH] = integral_r;
        assign peak_w[g*ADC_WIDTH +: ADC_WIDTH]       = peak_r;
        assign baseline_w[g*BLO_W +: BLO_W]           = bl_out_r;
        assign sat_w[g]                               = sat_r;
        assign ovf_w[g]                               = ovf_r;
    end

    assign INTEGRAL  = integral_w;
    assign PEAK      = peak_w;
    assign BASELINE  = baseline_w;
    assign SATURATED = sat_w;
    assign OVERFLOW  = ovf_w;

endmodule

// File: tb/tb_shwr_integral_mc.sv
module tb_shwr_integral_mc;

    localparam int NCH = 3;
    localparam int AW  = 12;
    localparam int IW  = 19;
    localparam int BW  = 14;

    logic                CLK120 = 1'b0;
    logic                RESET;
    logic [NCH*AW-1:0]   ADC;
    logic                TRIGGER;
    logic [11:0]         WINDOW_LEN;
    logic [AW-1:0]       BASELINE_INIT;
    logic                BUSY;
    logic                DONE;
    logic [NCH*IW-1:0]   INTEGRAL;
    logic [NCH*AW-1:0]   PEAK;
    logic [NCH*BW-1:0]   BASELINE;
    logic [NCH-1:0]      SATURATED;
    logic [NCH-1:0]      OVERFLOW;

    int tests = 0;
    int fails = 0;
    int cyc;
    int dones;

    shwr_integral_mc dut (
        .CLK120(CLK120), .RESET(RESET), .ADC(ADC), .TRIGGER(TRIGGER),
        .WINDOW_LEN(WINDOW_LEN), .BASELINE_INIT(BASELINE_INIT),
        .BUSY(BUSY), .DONE(DONE), .INTEGRAL(INTEGRAL), .PEAK(PEAK),
        .BASELINE(BASELINE), .SATURATED(SATURATED), .OVERFLOW(OVERFLOW)
    );

    always #4 CLK120 = ~CLK120;

    function automatic logic [31:0] f_int(input int c);
        return 32'(INTEGRAL[c*IW +: IW]);
    endfunction
    function automatic logic [31:0] f_peak(input int c);
        return 32'(PEAK[c*AW +: AW]);
    endfunction
    function automatic logic [31:0] f_bl(input int c);
        return 32'(BASELINE[c*BW +: BW]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic step(input int n);
        repeat (n) @(posedge CLK120);
        #1;
    endtask

    task automatic set_adc(input int a0, input int a1, input int a2);
        ADC = {AW'(a2), AW'(a1), AW'(a0)};
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (DONE !== 1'b1 && n < budget) begin
            step(1);
            n++;
        end
    endtask

    initial begin
        RESET = 1'b1; TRIGGER = 1'b0; WINDOW_LEN = 12'd64; BASELINE_INIT = 12'd250;
        set_adc(250, 250, 250);
        step(3);

        // Reset state
        chk("rst_busy", 32'(BUSY), 0);
        chk("rst_done", 32'(DONE), 0);
        chk("rst_int0", f_int(0), 0);
        chk("rst_peak2", f_peak(2), 0);
        chk("rst_bl0", f_bl(0), 1000);
        chk("rst_bl2", f_bl(2), 1000);
        chk("rst_flags", 32'({SATURATED, OVERFLOW}), 0);
        RESET = 1'b0;
        step(100);

        // 1: flat input, 64-bin window
        TRIGGER = 1'b1;
        step(1);
        TRIGGER = 1'b0;
        chk("t1_busy_t1", 32'(BUSY), 1);
        wait_done(200, cyc);
        chk("t1_latency", 32'(cyc + 1), 65);
        for (int c = 0; c < NCH; c++) begin
            chk("t1_int", f_int(c), 0);
            chk("t1_peak", f_peak(c), 0);
            chk("t1_bl", f_bl(c), 1000);
        end
        chk("t1_flags", 32'({SATURATED, OVERFLOW}), 0);
        step(1);
        chk("t1_done_pulse", 32'(DONE), 0);
        chk("t1_busy_after", 32'(BUSY), 0);
        step(5);

        // 2: ch0 pulse of 350 for 10 cycles starting 3 cycles after trigger
        TRIGGER = 1'b1;
        step(1);
        TRIGGER = 1'b0;
        step(2);
        set_adc(350, 250, 250);
        step(10);
        set_adc(250, 250, 250);
        wait_done(200, cyc);
        chk("t2_latency", 32'(cyc + 13), 65);
        chk("t2_int0", f_int(0), 1000);
        chk("t2_peak0", f_peak(0), 100);
        chk("t2_int1", f_int(1), 0);
        chk("t2_int2", f_int(2), 0);
        chk("t2_sat", 32'(SATURATED), 0);
        step(5);

        // 3: ch1 at 4095 for 20 samples inside the window
        TRIGGER = 1'b1;
        step(1);
        TRIGGER = 1'b0;
        set_adc(250, 4095, 250);
        step(20);
        set_adc(250, 250, 250);
        wait_done(200, cyc);
        chk("t3_sat", 32'(SATURATED), 32'b010);
        chk("t3_peak1", f_peak(1), 3845);
        chk("t3_int1", f_int(1), 76900);
        chk("t3_peak0", f_peak(0), 0);
        chk("t3_ovf", 32'(OVERFLOW), 0);
        step(5);

        // 4: longest window, ch2 pinned high (overflow), ch0 below baseline
        WINDOW_LEN = 12'd4095;
        TRIGGER = 1'b1;
        set_adc(200, 250, 4095);
        step(1);
        TRIGGER = 1'b0;
        step(3000);
        set_adc(250, 250, 250);
        wait_done(2000, cyc);
        chk("t4_latency", 32'(cyc + 3001), 4096);
        chk("t4_int2", f_int(2), 524287);
        chk("t4_ovf", 32'(OVERFLOW), 32'b100);
        chk("t4_int0", f_int(0), 0);
        chk("t4_int1", f_int(1), 0);
        chk("t4_peak2", f_peak(2), 3845);
        chk("t4_sat", 32'(SATURATED), 32'b100);
        step(5);

        // 5: TRIGGER held high with WINDOW_LEN=0 -> one-bin windows, DONE every 3rd cycle
        WINDOW_LEN = 12'd0;
        TRIGGER = 1'b1;
        dones = 0;
        for (int k = 1; k <= 9; k++) begin
            step(1);
            chk("t5_busy", 32'(BUSY), (k % 3 == 1) ? 1 : 0);
            chk("t5_done", 32'(DONE), (k % 3 == 2) ? 1 : 0);
            if (DONE === 1'b1) dones++;
        end
        TRIGGER = 1'b0;
        chk("t5_dones", 32'(dones), 3);
        chk("t5_int2", f_int(2), 0);
        chk("t5_ovf", 32'(OVERFLOW), 0);
        step(5);

        // 6a: baseline step 250 -> 260, then a window with a small ch0 excess
        set_adc(260, 260, 260);
        step(700);
        WINDOW_LEN = 12'd20;
        TRIGGER = 1'b1;
        set_adc(270, 260, 260);
        step(1);
        TRIGGER = 1'b0;
        step(12);
        set_adc(260, 260, 260);
        wait_done(100, cyc);
        chk("t6_latency", 32'(cyc + 13), 21);
        for (int c = 0; c < NCH; c++) chk("t6_bl", f_bl(c), 1040);
        chk("t6_int0", f_int(0), 130);
        chk("t6_peak0", f_peak(0), 10);
        chk("t6_int1", f_int(1), 0);
        step(5);

        // 6b: RESET in the middle of a window
        WINDOW_LEN = 12'd64;
        TRIGGER = 1'b1;
        step(1);
        TRIGGER = 1'b0;
        step(10);
        chk("t6_busy_pre", 32'(BUSY), 1);
        RESET = 1'b1;
        step(1);
        RESET = 1'b0;
        chk("t6_rst_busy", 32'(BUSY), 0);
        chk("t6_rst_int0", f_int(0), 0);
        chk("t6_rst_peak0", f_peak(0), 0);
        chk("t6_rst_bl0", f_bl(0), 1000);
        chk("t6_rst_bl1", f_bl(1), 1000);
        dones = 0;
        for (int k = 0; k < 80; k++) begin
            step(1);
            if (DONE === 1'b1 || BUSY === 1'b1) dones++;
        end
        chk("t6_no_done", 32'(dones), 0);
        chk("t6_bl_hold", f_bl(2), 1000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
